binary_game_core: RTL and testbench

Parametrised game core for the binary-number guessing game. It merges round sequencing, per-level countdown, target generation and answer checking into one clocked block with lives and score. It sits between the debounced button/switch inputs and the LCD display driver, and supersedes the separate fixed 4-bit logic, timer, generator and comparator blocks.

---
 rtl/binary_game_core.sv | 126 ++++++++++++
 tb/tb_binary_game_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_game_core.sv
// Game core for the binary-number guessing game: round sequencing, per-level
// countdown, LFSR target generation and answer checking, with lives and score.
module binary_game_core #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LEVELS   = 8,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned T_START  = 20,
  parameter int unsigned T_STEP   = 2,
  parameter int unsigned T_MIN    = 5,
  parameter int unsigned LIVES    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             guess,
  input  logic [WIDTH-1:0] sw,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] target,
  output logic [7:0]       level,
  output logic [7:0]       timeleft,
  output logic [3:0]       lives,
  output logic [15:0]      score,
  output logic             hit,
  output logic             miss
);

  localparam int unsigned     PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PSC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_WIN = 2'd2, S_LOSE = 2'd3} state_t;

  state_t        st;
  logic [15:0]   lfsr;
  logic [PW-1:0] psc;

  assign state = st;

  // Time allowed at a level; the subtraction is only taken when it stays
  // above the floor, so it can never wrap.
  function automatic logic [7:0] level_time(input logic [7:0] lvl);
    int unsigned dec;
    if (lvl == 8'd0) return 8'(T_START);
    dec = (32'(lvl) - 32'd1) * T_STEP;
    if (dec >= T_START - T_MIN) return 8'(T_MIN);
    return 8'(T_START - dec);
  endfunction

  logic          tick;
  logic [PW-1:0] psc_next;
  logic [16:0]   score_sum;
  logic [15:0]   score_next;

  assign tick       = (psc == PSC_LAST);
  assign psc_next   = tick ? '0 : psc + 1'b1;
  assign score_sum  = {1'b0, score} + {9'd0, timeleft};
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Free-running Fibonacci LFSR (taps 16,14,13,11), advances in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Game FSM: start beats guess, guess beats timeout, timeout beats tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      target   <= '0;
      level    <= 8'd0;
      timeleft <= 8'd0;
      lives    <= 4'd0;
      score    <= 16'd0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      psc      <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (start) begin
        // start initialises from any state, including a restart mid-game
        st       <= S_PLAY;
        level    <= 8'd1;
        lives    <= 4'(LIVES);
        score    <= 16'd0;
        target   <= lfsr[WIDTH-1:0];
        timeleft <= level_time(8'd1);
        psc      <= '0;
      end else if (st == S_PLAY) begin
        if (guess) begin
          if (sw == target) begin
            hit   <= 1'b1;
            score <= score_next;
            if (level == 8'(LEVELS)) begin
              st <= S_WIN;
            end else begin
              level    <= level + 8'd1;
              target   <= lfsr[WIDTH-1:0];
              timeleft <= level_time(level + 8'd1);
              psc      <= '0;
            end
          end else begin
            // wrong answer: timer keeps running but a coincident tick is dropped
            miss  <= 1'b1;
            lives <= lives - 4'd1;
            if (lives == 4'd1) st <= S_LOSE;
            else               psc <= psc_next;
          end
        end else if (timeleft == 8'd0) begin
          miss  <= 1'b1;
          lives <= lives - 4'd1;
          if (lives == 4'd1) begin
            st <= S_LOSE;
          end else begin
            target   <= lfsr[WIDTH-1:0];
            timeleft <= level_time(level);
            psc      <= '0;
          end
        end else begin
          psc <= psc_next;
          if (tick) timeleft <= timeleft - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_game_core.sv
// Directed bench for binary_game_core with small test-plan parameters.
module tb_binary_game_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        guess = 1'b0;
  logic [3:0]  sw = 4'd0;
  logic [1:0]  state;
  logic [3:0]  target;
  logic [7:0]  level;
  logic [7:0]  timeleft;
  logic [3:0]  lives;
  logic [15:0] score;
  logic        hit;
  logic        miss;

  int total  = 0;
  int passed = 0;

  logic [15:0] m;   // reference LFSR
  logic [15:0] pm;  // reference LFSR value seen by the most recent edge
  logic [3:0]  t;   // expected current target

  binary_game_core #(
    .WIDTH(4), .LEVELS(3), .TICK_DIV(4), .T_START(5), .T_STEP(1), .T_MIN(4), .LIVES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess(guess), .sw(sw),
    .state(state), .target(target), .level(level), .timeleft(timeleft),
    .lives(lives), .score(score), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  // reference LFSR, x^16+x^14+x^13+x^11, seed ACE1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 16'hACE1;
    else        m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             passed++;
  endtask

  task automatic cyc();
    pm = m;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    t = pm[3:0];
  endtask

  task automatic do_guess(input logic [3:0] v);
    sw    = v;
    guess = 1'b1;
    cyc();
    guess = 1'b0;
  endtask

  initial begin
    // reset state
    cyc(); cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_timeleft", 32'(timeleft), 32'd0);
    chk("rst_lives", 32'(lives), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    rst_n = 1'b1;
    cyc();

    // guess in IDLE is ignored even though sw matches the reset target
    do_guess(4'd0);
    chk("idle_guess_state", 32'(state), 32'd0);
    chk("idle_guess_hit", 32'(hit), 32'd0);

    // three immediate correct guesses: 5 + 4 + 4 = 13, then WIN
    pulse_start();
    chk("start_state", 32'(state), 32'd1);
    chk("start_level", 32'(level), 32'd1);
    chk("start_lives", 32'(lives), 32'd2);
    chk("start_timeleft", 32'(timeleft), 32'd5);
    chk("start_score", 32'(score), 32'd0);
    chk("start_target", 32'(target), 32'(t));
    do_guess(t); t = pm[3:0];
    chk("l1_hit", 32'(hit), 32'd1);
    chk("l1_miss", 32'(miss), 32'd0);
    chk("l1_level", 32'(level), 32'd2);
    chk("l1_timeleft", 32'(timeleft), 32'd4);
    chk("l1_score", 32'(score), 32'd5);
    chk("l1_target", 32'(target), 32'(t));
    do_guess(t); t = pm[3:0];
    chk("l2_hit", 32'(hit), 32'd1);
    chk("l2_level", 32'(level), 32'd3);
    chk("l2_timeleft_floor", 32'(timeleft), 32'd4);
    chk("l2_score", 32'(score), 32'd9);
    chk("l2_target", 32'(target), 32'(t));
    do_guess(t);
    chk("l3_hit", 32'(hit), 32'd1);
    chk("l3_state_win", 32'(state), 32'd2);
    chk("l3_level", 32'(level), 32'd3);
    chk("l3_timeleft", 32'(timeleft), 32'd4);
    chk("l3_score", 32'(score), 32'd13);
    chk("l3_target_hold", 32'(target), 32'(t));
    cyc();
    chk("win_hit_clear", 32'(hit), 32'd0);
    chk("win_state_hold", 32'(state), 32'd2);
    do_guess(t);
    chk("win_guess_state", 32'(state), 32'd2);
    chk("win_guess_hit", 32'(hit), 32'd0);
    chk("win_guess_score", 32'(score), 32'd13);

    // two wrong guesses -> LOSE
    pulse_start();
    do_guess(t ^ 4'd1);
    chk("w1_miss", 32'(miss), 32'd1);
    chk("w1_hit", 32'(hit), 32'd0);
    chk("w1_lives", 32'(lives), 32'd1);
    chk("w1_state", 32'(state), 32'd1);
    chk("w1_target_keep", 32'(target), 32'(t));
    chk("w1_timeleft", 32'(timeleft), 32'd5);
    cyc();
    chk("w1_miss_clear", 32'(miss), 32'd0);
    do_guess(t ^ 4'd1);
    chk("w2_miss", 32'(miss), 32'd1);
    chk("w2_lives", 32'(lives), 32'd0);
    chk("w2_state_lose", 32'(state), 32'd3);
    chk("w2_target_keep", 32'(target), 32'(t));

    // countdown 5..0 at 4 cycles per second, then timeout miss
    pulse_start();
    chk("c_start_state", 32'(state), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("countdown", 32'(timeleft), 32'(5 - k / 4));
      chk("countdown_miss", 32'(miss), 32'd0);
    end
    cyc(); t = pm[3:0];
    chk("to_miss", 32'(miss), 32'd1);
    chk("to_lives", 32'(lives), 32'd1);
    chk("to_timeleft", 32'(timeleft), 32'd5);
    chk("to_state", 32'(state), 32'd1);
    chk("to_target", 32'(target), 32'(t));

    // correct guess in the timeleft==0 cycle wins over the timeout
    for (int k = 1; k <= 20; k++) cyc();
    chk("z_timeleft", 32'(timeleft), 32'd0);
    do_guess(t); t = pm[3:0];
    chk("z_hit", 32'(hit), 32'd1);
    chk("z_miss", 32'(miss), 32'd0);
    chk("z_lives", 32'(lives), 32'd1);
    chk("z_level", 32'(level), 32'd2);
    chk("z_score", 32'(score), 32'd0);
    chk("z_timeleft_reload", 32'(timeleft), 32'd4);

    // start at level 2 restarts; the coincident guess is ignored
    cyc();
    start = 1'b1; guess = 1'b1; sw = t;
    cyc();
    start = 1'b0; guess = 1'b0;
    t = pm[3:0];
    chk("rs_state", 32'(state), 32'd1);
    chk("rs_level", 32'(level), 32'd1);
    chk("rs_lives", 32'(lives), 32'd2);
    chk("rs_score", 32'(score), 32'd0);
    chk("rs_hit", 32'(hit), 32'd0);
    chk("rs_timeleft", 32'(timeleft), 32'd5);
    chk("rs_target", 32'(target), 32'(t));

    // async reset right after a hit clears everything within the cycle
    do_guess(t);
    chk("pre_rst_hit", 32'(hit), 32'd1);
    chk("pre_rst_score", 32'(score), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_target", 32'(target), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_timeleft", 32'(timeleft), 32'd0);
    chk("arst_lives", 32'(lives), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_hit", 32'(hit), 32'd0);
    chk("arst_miss", 32'(miss), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
